// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Two-entry pipeline stage register with skid buffer.
//                A main entry drives the outputs. A skid entry catches the
//                word that arrives in the cycle downstream stalls. in_ready
//                is decoded from the state register only, so there is no
//                combinational path from out_ready back to in_ready.
//                A synchronous flush empties the stage (bubble insertion).
//  Ports       :
//    clock       in   1       rising-edge clock
//    reset       in   1       asynchronous active-high reset
//    flush       in   1       synchronous clear; has priority over traffic
//    in_valid    in   1       upstream offers a word
//    in_ready    out  1       stage can take a word this cycle
//    in_ctrl     in   CTRL_W  upstream control field
//    in_data     in   DATA_W  upstream data field
//    out_valid   out  1       a word is available downstream
//    out_ready   in   1       downstream takes the word this cycle
//    out_ctrl    out  CTRL_W  main-entry control (zero when out_valid = 0)
//    out_data    out  DATA_W  main-entry data
//    occupancy   out  2       words held: 0, 1 or 2
//    accept_cnt  out  CNT_W   count of accepted words (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int CTRL_W          = 12,
  parameter int DATA_W          = 175,
  parameter int FLUSH_ZERO_DATA = 0,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  accept_cnt
);

  // --------------------------------------------------------------------------
  // State encoding; the encoding doubles as the occupancy value.
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_one   = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  localparam logic             c_flush_zero_data = (FLUSH_ZERO_DATA != 0);
  localparam logic [CNT_W-1:0] c_cnt_one         = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_accept_cnt;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_deliver;

  // Entry load controls produced by the next-state decode.
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid_in;

  // --------------------------------------------------------------------------
  // Handshake qualifiers. Flush masks both sides so that an in_valid during a
  // flush cycle is not taken and nothing counts as delivered.
  // --------------------------------------------------------------------------
  assign w_in_ready  = (r_state != c_st_full);
  assign w_out_valid = (r_state != c_st_empty);
  assign w_accept    = in_valid  & w_in_ready  & ~flush;
  assign w_deliver   = w_out_valid & out_ready & ~flush;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and entry-load decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    if (flush) begin
      w_state_nxt = c_st_empty;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = c_st_one;
          end
        end
        c_st_one: begin
          if (w_accept && w_deliver) begin
            // Pass-through: the new word replaces the one leaving.
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            // Downstream stalled: park the new word behind the main entry.
            w_load_skid_in = 1'b1;
            w_state_nxt    = c_st_full;
          end else if (w_deliver) begin
            w_state_nxt = c_st_empty;
          end
        end
        c_st_full: begin
          if (w_deliver) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = c_st_one;
          end
        end
        default: begin
          w_state_nxt = c_st_empty;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (state-only for in_ready / occupancy)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = w_in_ready;
    out_valid = w_out_valid;
    out_ctrl  = w_out_valid ? r_main_ctrl : {CTRL_W{1'b0}};
    out_data  = r_main_data;
    case (r_state)
      c_st_empty: occupancy = 2'd0;
      c_st_one:   occupancy = 2'd1;
      c_st_full:  occupancy = 2'd2;
      default:    occupancy = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control fields: always cleared by flush so no stale write enable can
  // leak into a later stage.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else if (flush) begin
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid_in) begin
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data fields: cleared by flush only when configured; otherwise held, since
  // out_ctrl being zero already marks the word as dead.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_data <= {DATA_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
    end else if (flush) begin
      if (c_flush_zero_data) begin
        r_main_data <= {DATA_W{1'b0}};
        r_skid_data <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_load_main_in) begin
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid_in) begin
        r_skid_data <= in_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accept counter (wraps naturally; flush never accepts so never counts)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_accept_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + c_cnt_one;
    end
  end

  assign accept_cnt = r_accept_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Directed self-checking bench for pipe_skid_reg. Two
//                instances share stimulus: dut_a uses defaults, dut_b uses a
//                4-bit counter and zeroes data on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

  localparam int c_ctrl_w = 12;
  localparam int c_data_w = 175;

  logic                clock;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic [c_ctrl_w-1:0] in_ctrl;
  logic [c_data_w-1:0] in_data;
  logic                out_ready;

  logic                a_in_ready, a_out_valid;
  logic [c_ctrl_w-1:0] a_out_ctrl;
  logic [c_data_w-1:0] a_out_data;
  logic [1:0]          a_occ;
  logic [15:0]         a_cnt;

  logic                b_in_ready, b_out_valid;
  logic [c_ctrl_w-1:0] b_out_ctrl;
  logic [c_data_w-1:0] b_out_data;
  logic [1:0]          b_occ;
  logic [3:0]          b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_skid_reg #(.CTRL_W(c_ctrl_w), .DATA_W(c_data_w), .FLUSH_ZERO_DATA(0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ), .accept_cnt(a_cnt)
  );

  pipe_skid_reg #(.CTRL_W(c_ctrl_w), .DATA_W(c_data_w), .FLUSH_ZERO_DATA(1), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ), .accept_cnt(b_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [c_ctrl_w-1:0] c, input int d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = c_data_w'(d);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 12'h000, 0);
    step(); step();
    if (a_out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); n_errors++; end
    n_checks++;
    if (a_out_ctrl !== 12'h000 || a_out_data !== '0) begin $display("FAIL reset_out_fields ctrl=%0h data=%0h exp=0", a_out_ctrl, a_out_data); n_errors++; end
    n_checks++;
    if (a_occ !== 2'd0 || a_cnt !== 16'd0 || a_in_ready !== 1'b1) begin
      $display("FAIL reset_status occ=%0d cnt=%0d in_ready=%0b exp=0/0/1", a_occ, a_cnt, a_in_ready); n_errors++;
    end
    n_checks++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    offer(1'b1, 12'h0A5, 7);
    step();
    offer(1'b0, 12'h000, 0);
    if (a_out_valid !== 1'b1 || a_out_ctrl !== 12'h0A5 || a_out_data !== c_data_w'(7)) begin
      $display("FAIL single_word valid=%0b ctrl=%0h data=%0h exp=1/0a5/7", a_out_valid, a_out_ctrl, a_out_data); n_errors++;
    end
    n_checks++;
    if (a_cnt !== 16'd1 || a_occ !== 2'd1) begin $display("FAIL single_cnt cnt=%0d occ=%0d exp=1/1", a_cnt, a_occ); n_errors++; end
    n_checks++;
    step();
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 12'h000 || a_occ !== 2'd0) begin
      $display("FAIL single_drain valid=%0b ctrl=%0h occ=%0d exp=0/0/0", a_out_valid, a_out_ctrl, a_occ); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(1'b1, 12'h111, 'hA);
    step();
    if (a_occ !== 2'd1 || a_out_ctrl !== 12'h111) begin $display("FAIL bp_first occ=%0d ctrl=%0h exp=1/111", a_occ, a_out_ctrl); n_errors++; end
    n_checks++;
    offer(1'b1, 12'h222, 'hB);
    step();
    if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_ctrl !== 12'h111 || a_out_data !== c_data_w'('hA)) begin
      $display("FAIL bp_full occ=%0d in_ready=%0b ctrl=%0h data=%0h exp=2/0/111/a", a_occ, a_in_ready, a_out_ctrl, a_out_data); n_errors++;
    end
    n_checks++;
    // Word C offered while full; out_ready rising must not reopen the input.
    offer(1'b1, 12'h333, 'hC);
    out_ready = 1'b1;
    #1;
    if (a_in_ready !== 1'b0) begin $display("FAIL bp_no_comb_ready in_ready=%0b exp=0", a_in_ready); n_errors++; end
    n_checks++;
    step();
    offer(1'b0, 12'h000, 0);
    if (a_occ !== 2'd1 || a_out_ctrl !== 12'h222 || a_out_data !== c_data_w'('hB) || a_in_ready !== 1'b1) begin
      $display("FAIL bp_second occ=%0d ctrl=%0h data=%0h in_ready=%0b exp=1/222/b/1", a_occ, a_out_ctrl, a_out_data, a_in_ready); n_errors++;
    end
    n_checks++;
    step();
    if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_cnt !== 16'd3) begin
      $display("FAIL bp_drain occ=%0d valid=%0b cnt=%0d exp=0/0/3", a_occ, a_out_valid, a_cnt); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(1'b1, 12'h444, 'hD);
    step();
    offer(1'b1, 12'h555, 'hE);
    step();
    if (a_occ !== 2'd2 || a_cnt !== 16'd5) begin $display("FAIL flush_prefill occ=%0d cnt=%0d exp=2/5", a_occ, a_cnt); n_errors++; end
    n_checks++;
    flush = 1'b1; out_ready = 1'b1;
    offer(1'b1, 12'h666, 'hF);
    step();
    flush = 1'b0;
    offer(1'b0, 12'h000, 0);
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 12'h000 || a_occ !== 2'd0 || a_in_ready !== 1'b1) begin
      $display("FAIL flush_state valid=%0b ctrl=%0h occ=%0d in_ready=%0b exp=0/0/0/1", a_out_valid, a_out_ctrl, a_occ, a_in_ready); n_errors++;
    end
    n_checks++;
    if (a_cnt !== 16'd5 || b_cnt !== 4'd5) begin $display("FAIL flush_cnt a=%0d b=%0d exp=5/5", a_cnt, b_cnt); n_errors++; end
    n_checks++;
    if (a_out_data !== c_data_w'('hD)) begin $display("FAIL flush_data_held got=%0h exp=d", a_out_data); n_errors++; end
    n_checks++;
    if (b_out_data !== '0 || b_out_valid !== 1'b0) begin $display("FAIL flush_data_zero data=%0h valid=%0b exp=0/0", b_out_data, b_out_valid); n_errors++; end
    n_checks++;
    step();
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin $display("FAIL flush_no_ghost valid=%0b occ=%0d exp=0/0", a_out_valid, a_occ); n_errors++; end
    n_checks++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(1'b1, 12'h777, 'h17);
    step();
    offer(1'b1, 12'h888, 'h18);
    step();
    offer(1'b0, 12'h000, 0);
    if (a_occ !== 2'd2) begin $display("FAIL areset_prefill occ=%0d exp=2", a_occ); n_errors++; end
    n_checks++;
    #2 reset = 1'b1;
    #1;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 12'h000 || a_out_data !== '0 || a_in_ready !== 1'b1 || a_occ !== 2'd0 || a_cnt !== 16'd0) begin
      $display("FAIL areset_immediate valid=%0b ctrl=%0h data=%0h in_ready=%0b occ=%0d cnt=%0d exp=0/0/0/1/0/0",
               a_out_valid, a_out_ctrl, a_out_data, a_in_ready, a_occ, a_cnt); n_errors++;
    end
    n_checks++;
    #2 reset = 1'b0;
    out_ready = 1'b1;
    step();
    if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || b_out_valid !== 1'b0) begin
      $display("FAIL areset_release a_valid=%0b occ=%0d b_valid=%0b exp=0/0/0", a_out_valid, a_occ, b_out_valid); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      offer(1'b1, 12'(i), 1000 + i);
      step();
      if (a_occ !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== c_data_w'(1000 + i) || a_out_ctrl !== 12'(i)) begin
        bad++;
        if (bad <= 4) $display("FAIL stream_word i=%0d occ=%0d data=%0h exp_occ=1 exp_data=%0h", i, a_occ, a_out_data, 1000 + i);
      end
    end
    if (bad != 0) n_errors++;
    n_checks++;
    offer(1'b0, 12'h000, 0);
    if (a_cnt !== 16'd100 || b_cnt !== 4'd4) begin $display("FAIL stream_cnt a=%0d b=%0d exp=100/4", a_cnt, b_cnt); n_errors++; end
    n_checks++;
    step();
    if (a_occ !== 2'd0) begin $display("FAIL stream_drain occ=%0d exp=0", a_occ); n_errors++; end
    n_checks++;
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      offer(1'b1, 12'h0F0, i);
      step();
    end
    offer(1'b0, 12'h000, 0);
    if (b_cnt !== 4'd1) begin $display("FAIL wrap_cnt4 got=%0d exp=1", b_cnt); n_errors++; end
    n_checks++;
    if (a_cnt !== 16'd17) begin $display("FAIL wrap_cnt16 got=%0d exp=17", a_cnt); n_errors++; end
    n_checks++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 12, width of the control field (write enables, select and op codes).
REQ-002 SHALL have parameter DATA_W, default 175, width of the data field (register addresses, operands, PC, immediates).
REQ-003 SHALL have parameter FLUSH_ZERO_DATA, default 0; when 1, flush also zeroes stored data.
REQ-004 SHALL have parameter CNT_W, default 16, width of the accept counter.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous pipeline clear (bubble insertion).
REQ-008 SHALL have port in_valid  input  1  upstream has a stage word.
REQ-009 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control field.
REQ-011 SHALL have port in_data  input  DATA_W  upstream data field.
REQ-012 SHALL have port out_valid  output  1  stage word available downstream.
REQ-013 SHALL have port out_ready  input  1  downstream takes the word this cycle.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  stored control field.
REQ-015 SHALL have port out_data  output  DATA_W  stored data field.
REQ-016 SHALL have port occupancy  output  2  number of held words (0, 1 or 2).
REQ-017 SHALL have port accept_cnt  output  CNT_W  count of accepted words.

Function
REQ-018 SHALL hold two entries, main and skid, and a state register with states EMPTY, ONE, FULL.
REQ-019 SHALL define accept = in_valid & in_ready & !flush, and deliver = out_valid & out_ready & !flush.
REQ-020 SHALL drive in_ready = (state != FULL), decoded from state registers only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (state != EMPTY), with out_ctrl/out_data taken from the main entry.
REQ-022 SHALL force out_ctrl to all-zero whenever out_valid = 0.
REQ-023 SHALL on EMPTY: accept -> main <= in, go ONE; otherwise stay EMPTY.
REQ-024 SHALL on ONE: accept & deliver -> main <= in, stay ONE; accept only -> skid <= in, go FULL; deliver only -> go EMPTY; neither -> hold.
REQ-025 SHALL on FULL: deliver -> main <= skid, go ONE; otherwise hold both entries.
REQ-026 SHALL give a latency of 1 cycle: a word accepted at edge N is on out_* with out_valid = 1 after edge N.
REQ-027 SHALL preserve order and never drop or duplicate a word, except on flush.
REQ-028 SHALL on flush (priority over accept/deliver) go EMPTY, discard both entries and zero the main and skid control fields; data SHALL be zeroed only if FLUSH_ZERO_DATA = 1, else held.
REQ-029 SHALL treat in_valid asserted during a flush cycle as not accepted.
REQ-030 SHALL drive occupancy as 0/1/2 for EMPTY/ONE/FULL.
REQ-031 SHALL increment accept_cnt by 1 on each accept, wrap modulo 2^CNT_W, and leave it unaffected by flush.
REQ-032 SHALL leave in_ready = 0 in FULL even when out_ready = 1 in the same cycle; the input reopens the next cycle.

Reset
REQ-033 SHALL, while reset = 1 and independent of clock, set state EMPTY and both entries and accept_cnt to zero, giving out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, accept_cnt = 0 and in_ready = 1.
REQ-034 SHALL discard any held word when reset is asserted mid-operation, including in FULL; no word SHALL appear after reset release until a new accept.

Verification
REQ-035 SHALL cover: reset, then in_valid = 1 with in_ctrl = 0x0A5 and in_data = 7, out_ready = 1 -> one cycle later out_valid = 1, out_ctrl = 0x0A5, out_data = 7, accept_cnt = 1.
REQ-036 SHALL cover: out_ready = 0 while words A and B are offered -> occupancy = 2 and in_ready = 0; then out_ready = 1 -> A then B delivered in order, occupancy 1 then 0.
REQ-037 SHALL cover: FULL plus flush = 1 with in_valid = 1 -> next cycle out_valid = 0, out_ctrl = 0, occupancy = 0 and accept_cnt unchanged; with FLUSH_ZERO_DATA = 1, out_data = 0.
REQ-038 SHALL cover: continuous in_valid = out_ready = 1 for 100 cycles -> throughput of 1 word/cycle, occupancy = 1 throughout, accept_cnt = 100.
REQ-039 SHALL cover: CNT_W = 4 and 17 accepts -> accept_cnt = 1 (wrap).
REQ-040 SHALL cover: asynchronous reset pulse between clock edges while FULL -> outputs zero immediately, in_ready = 1 and occupancy = 0.
